// File: rtl/rtl_settings_pkg.sv
// Shared settings for the memory-checker block: CSR layout, address width,
// and the enums used by test_control.
package rtl_settings_pkg;

   localparam int ADDR_W         = 16;
   localparam int CSR_TEST_PARAM = 0;
   localparam int CSR_SET_ADDR   = 1;

   localparam int OP_LSB  = 14;
   localparam int OP_W    = 2;
   localparam int CNT_LSB = 16;

   typedef enum logic [1:0] {
      READ_ONLY  = 2'b00,
      WRITE_ONLY = 2'b01,
      WRITE_READ = 2'b10,
      OP_RSVD    = 2'b11
   } test_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      ISSUE = 2'b10,
      DONE  = 2'b11
   } test_ctrl_state_t;

endpackage

// File: rtl/test_control.sv
// Sequences one memory-checker pass: prime the address generator, issue N
// commands, pulse done. Optional stall watchdog: TEST_CTRL_TIMEOUT_EN.
module test_control
   import rtl_settings_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int TIMEOUT_W = 12
) (
   input  logic                                       clk_i,
   input  logic                                       rst_n_i,
   input  logic                                       start_i,
   input  logic [CSR_SET_ADDR:CSR_TEST_PARAM][31:0]   test_param_i,
   output logic                                       test_start_o,
   output logic                                       next_addr_en_o,
   input  logic [ADDR_W-1:0]                          next_addr_i,
   output logic                                       cmd_valid_o,
   output logic                                       cmd_write_o,
   output logic [ADDR_W-1:0]                          cmd_addr_o,
   input  logic                                       cmd_ready_i,
   output logic                                       busy_o,
   output logic                                       done_o,
   output logic [CNT_W-1:0]                           trans_cnt_o,
   output logic                                       timeout_o
);

   test_ctrl_state_t state_q, state_d;
   test_op_t         mode_q, mode_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rd_phase_q, rd_phase_d;
   logic             timeout_q, timeout_d;
   logic             test_start_q, test_start_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic             xfer, last_phase, cmd_write;
   logic             unused_csr_bits;

`ifdef TEST_CTRL_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] STALL_MAX = {TIMEOUT_W{1'b1}};
   logic [TIMEOUT_W-1:0] stall_q, stall_d;
`endif

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      rd_phase_d = rd_phase_q;
      timeout_d  = timeout_q;
`ifdef TEST_CTRL_TIMEOUT_EN
      stall_d    = stall_q;
`endif

      xfer       = valid_q & cmd_ready_i;
      // WRITE_READ needs both phases before the generator may advance
      last_phase = xfer & ((mode_q != WRITE_READ) | rd_phase_q);

      case (mode_q)
         WRITE_ONLY: cmd_write = 1'b1;
         WRITE_READ: cmd_write = ~rd_phase_q;
         default:    cmd_write = 1'b0;
      endcase

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = START;
               mode_d  = test_op_t'(test_param_i[CSR_TEST_PARAM][OP_LSB +: OP_W]);
               n_d     = test_param_i[CSR_TEST_PARAM][CNT_LSB +: CNT_W];
            end
         end
         START: begin
            cnt_d      = '0;
            rd_phase_d = 1'b0;
            timeout_d  = 1'b0;
`ifdef TEST_CTRL_TIMEOUT_EN
            stall_d    = '0;
`endif
            if (n_q == '0 || mode_q == OP_RSVD) state_d = DONE;
            else                                state_d = ISSUE;
         end
         ISSUE: begin
            if (last_phase) begin
               cnt_d      = cnt_q + 1'b1;
               rd_phase_d = 1'b0;
               if (cnt_q + 1'b1 == n_q) state_d = DONE;
            end else if (xfer) begin
               rd_phase_d = 1'b1;
            end
`ifdef TEST_CTRL_TIMEOUT_EN
            if (xfer) begin
               stall_d = '0;
            end else begin
               stall_d = stall_q + 1'b1;
               if (stall_d == STALL_MAX) begin
                  timeout_d = 1'b1;
                  state_d   = DONE;
               end
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      test_start_d = (state_d == START);
      busy_d       = (state_d == START) || (state_d == ISSUE);
      valid_d      = (state_d == ISSUE);
      done_d       = (state_d == DONE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         mode_q       <= READ_ONLY;
         n_q          <= '0;
         cnt_q        <= '0;
         rd_phase_q   <= 1'b0;
         timeout_q    <= 1'b0;
         test_start_q <= 1'b0;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         done_q       <= 1'b0;
`ifdef TEST_CTRL_TIMEOUT_EN
         stall_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         n_q          <= n_d;
         cnt_q        <= cnt_d;
         rd_phase_q   <= rd_phase_d;
         timeout_q    <= timeout_d;
         test_start_q <= test_start_d;
         busy_q       <= busy_d;
         valid_q      <= valid_d;
         done_q       <= done_d;
`ifdef TEST_CTRL_TIMEOUT_EN
         stall_q      <= stall_d;
`endif
      end
   end

   assign test_start_o   = test_start_q;
   assign busy_o         = busy_q;
   assign cmd_valid_o    = valid_q;
   assign done_o         = done_q;
   assign trans_cnt_o    = cnt_q;
   assign next_addr_en_o = last_phase;
   assign cmd_write_o    = valid_q & cmd_write;
   assign cmd_addr_o     = next_addr_i;

`ifdef TEST_CTRL_TIMEOUT_EN
   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0 & timeout_q & TIMEOUT_W[0];
`endif

   assign unused_csr_bits = ^{test_param_i[CSR_SET_ADDR:CSR_TEST_PARAM+1],
                              test_param_i[CSR_TEST_PARAM][OP_LSB-1:0]};

endmodule

// File: doc/test_control.md
# test_control

Sequencer that runs one memory-checker test pass: on a CSR start pulse it primes the address generator, then issues the programmed number of read/write commands on the memory command channel, pulsing `next_addr_en_o` to advance the address generator after each address is fully serviced. It sits between the CSR block and the address generator / memory command path, and reports busy/done and a transaction count back to the CSRs.

## Interface
- `CNT_W`, 16: transaction counter width; matches `test_param_i[CSR_TEST_PARAM][31:16]`.
- `TIMEOUT_W`, 12: stall watchdog counter width (used only with `TEST_CTRL_TIMEOUT_EN`).
- `clk_i` in 1: single clock.
- `rst_n_i` in 1: reset, synchronous, active-low.
- `start_i` in 1: one-cycle start pulse from the CSR block.
- `test_param_i` in `[CSR_SET_ADDR:CSR_TEST_PARAM][31:0]`: CSR bank. Bits `[CSR_TEST_PARAM][15:14]` are the op mode; bits `[CSR_TEST_PARAM][31:16]` are the transaction count N.
- `test_start_o` out 1: prime pulse to the address generator.
- `next_addr_en_o` out 1: advance pulse to the address generator.
- `next_addr_i` in `ADDR_W`: current address from the generator.
- `cmd_valid_o` out 1: command valid.
- `cmd_write_o` out 1: 1 = write, 0 = read.
- `cmd_addr_o` out `ADDR_W`: command address.
- `cmd_ready_i` in 1: sink accepts the command when this and `cmd_valid_o` are both 1.
- `busy_o` out 1: test in progress.
- `done_o` out 1: one-cycle end-of-test pulse.
- `trans_cnt_o` out `CNT_W`: addresses completed in the current or last test.
- `timeout_o` out 1: sticky abort flag.

## Operation
- Op modes:
  - `00` READ_ONLY: one read per address.
  - `01` WRITE_ONLY: one write per address.
  - `10` WRITE_READ: a write, then a read of the same address.
  - `11`: reserved; the test completes with no commands.
- FSM states:
  - IDLE → START when `start_i` is 1. `start_i` is ignored in every other state.
  - START (1 cycle): `test_start_o` = 1; clear `trans_cnt_o`, the phase flag and `timeout_o`. Go to DONE if N = 0 or the mode is reserved; otherwise go to ISSUE.
  - ISSUE: `cmd_valid_o` = 1.
  - DONE (1 cycle): `done_o` = 1, then go to IDLE.
- Command outputs:
  - `cmd_addr_o` = `next_addr_i`, passed through combinationally. It is stable while a command is stalled, because the generator only moves on `next_addr_en_o`.
  - `cmd_write_o`: 0 in READ_ONLY; 1 in WRITE_ONLY; in WRITE_READ it equals `~rd_phase`.
- A transfer is `cmd_valid_o & cmd_ready_i`.
- The last phase of an address is any transfer in the single-phase modes, or the read transfer in WRITE_READ.
- A write transfer in WRITE_READ sets `rd_phase`. The address stays the same and there is no `next_addr_en_o`.
- On a last-phase transfer:
  - `next_addr_en_o` = 1 in the same cycle (combinational from the transfer).
  - `trans_cnt_o` increments and `rd_phase` clears.
  - If the new count equals N, go to DONE; otherwise stay in ISSUE.
- `busy_o` = 1 in START and ISSUE.
- Reset mid-test: return to IDLE in the next cycle. No further commands or pulses are issued.

## Timing
- Reset values: every output 0, including `trans_cnt_o` and `timeout_o`. The state is IDLE.
- `start_i` at cycle t: `test_start_o` at t+1; first `cmd_valid_o` at t+2, with `next_addr_i` already primed by the generator.
- Throughput: one command per cycle when `cmd_ready_i` is held 1. N addresses in READ_ONLY/WRITE_ONLY take N ISSUE cycles; in WRITE_READ they take 2N.
- `done_o` fires one cycle after the last transfer. A new `start_i` is accepted from the cycle after DONE.
- `trans_cnt_o` holds its value after DONE until the next START.

## Configuration
- `TEST_CTRL_TIMEOUT_EN` defined:
  - A counter of consecutive ISSUE cycles with `cmd_ready_i` = 0 runs; it clears on any transfer.
  - When the counter reaches 2^`TIMEOUT_W`−1, `timeout_o` is set (sticky), the FSM goes to DONE, and `done_o` pulses.
  - `trans_cnt_o` keeps the partial count.
- Undefined: no watchdog; a stall waits indefinitely. The `timeout_o` port remains and is tied to 0.

## Structure
- `rtl_settings_pkg` adds:
  - `test_op_t` (READ_ONLY, WRITE_ONLY, WRITE_READ, OP_RSVD).
  - `test_ctrl_state_t` (IDLE, START, ISSUE, DONE).
  - Constants for the op-mode and count bit fields.
- `ADDR_W` comes from the package.
- Single module, no sub-modules. The watchdog is an inline `ifdef` section.

## Test plan
- WRITE_ONLY, N=4, `cmd_ready_i`=1, `start_i` at t → `test_start_o` at t+1; four write commands at t+2..t+5 with `next_addr_en_o` each cycle; `done_o` at t+6; `trans_cnt_o`=4.
- WRITE_READ, N=2, ready=1 → command sequence W a0, R a0, W a1, R a1; `next_addr_en_o` only on the two reads; `done_o` 1 cycle after the last read.
- READ_ONLY, N=3, `cmd_ready_i` low for 5 cycles on the second command → `cmd_addr_o` and `cmd_valid_o` stable throughout the stall; `trans_cnt_o`=3 at done.
- N=0, and separately mode `11` → START then DONE; `cmd_valid_o` is never asserted.
- `rst_n_i`=0 mid-ISSUE with N=10 → IDLE next cycle, all outputs 0. `start_i` during busy is ignored.
- `TEST_CTRL_TIMEOUT_EN`, `TIMEOUT_W`=4, ready stuck 0 → `timeout_o`=1 and `done_o` after 15 stalled cycles; `trans_cnt_o`=0.
